// File: rtl/modn_down_counter_pkg.sv
// Shared definitions for the modulo-N down counter: width helper and variant select.
package modn_down_counter_pkg;

  // Implementation variant: plain D-flop register or per-bit toggle flops.
  typedef enum logic {ImplBehav, ImplStruct} impl_e;

  // Minimum register width able to hold 0..m-1 (at least one bit).
  function automatic int unsigned min_width(input int unsigned m);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(m)) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/modn_down_counter_if.sv
// Control and status bundle of one counter stage.
interface modn_down_counter_if #(
  parameter int unsigned WIDTH = 3
);
  logic             en;
  logic             bin;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             bout;
  logic             wrap;

  modport master (
    output en, bin, load, din,
    input  q, tc, bout, wrap
  );

  modport slave (
    input  en, bin, load, din,
    output q, tc, bout, wrap
  );
endinterface

// File: rtl/modn_down_counter_next_state.sv
// Combinational next-count and next-wrap logic: load clamp, decrement, wrap to MOD-1.
module modn_down_counter_next_state #(
  parameter int unsigned MOD   = 6,
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             cnt_i,
  output logic [WIDTH-1:0] q_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] TopVal = WIDTH'(MOD - 1);
  // One extra bit so MOD == 2**WIDTH compares correctly and never clamps.
  localparam logic [WIDTH:0]   ModVal = (WIDTH + 1)'(MOD);

  always_comb begin
    q_o    = q_i;
    wrap_o = 1'b0;
    if (load_i) begin
      q_o = ({1'b0, din_i} < ModVal) ? din_i : TopVal;
    end else if (cnt_i) begin
      if (q_i == '0) begin
        q_o    = TopVal;
        wrap_o = 1'b1;
      end else begin
        q_o = q_i - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/modn_down_counter.sv
// Modulo-N down counter stage with enable, parallel load, cascade borrow and wrap pulse.
module modn_down_counter
  import modn_down_counter_pkg::*;
#(
  parameter int unsigned MOD   = 6,
  parameter int unsigned WIDTH = 3,
  parameter impl_e       IMPL  = ImplBehav
) (
  input logic                clk,
  input logic                rst,
  modn_down_counter_if.slave bus
);

  if (MOD < 2 || WIDTH < min_width(MOD)) begin : g_bad_params
    $error("modn_down_counter: MOD=%0d illegal for WIDTH=%0d", MOD, WIDTH);
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             cnt;

  assign cnt = bus.en & bus.bin;

  modn_down_counter_next_state #(
    .MOD   (MOD),
    .WIDTH (WIDTH)
  ) u_next_state (
    .q_i    (q_q),
    .load_i (bus.load),
    .din_i  (bus.din),
    .cnt_i  (cnt),
    .q_o    (q_d),
    .wrap_o (wrap_d)
  );

  if (IMPL == ImplStruct) begin : g_tff
    logic [WIDTH-1:0] toggle;
    // Each bit flips only where the next count differs from the current one.
    assign toggle = q_q ^ q_d;

    always_ff @(posedge clk) begin
      if (rst) begin
        q_q <= '0;
      end else begin
        for (int i = 0; i < int'(WIDTH); i++) begin
          if (toggle[i]) begin
            q_q[i] <= ~q_q[i];
          end
        end
      end
    end
  end else begin : g_dff
    always_ff @(posedge clk) begin
      if (rst) begin
        q_q <= '0;
      end else begin
        q_q <= q_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.tc   = (q_q == '0);
  assign bus.bout = cnt & bus.tc;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_modn_down_counter.sv
// Directed and randomised checks of modn_down_counter, both variants plus a two-stage cascade.
module tb_modn_down_counter;
  import modn_down_counter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst_c;
  always #5 clk = ~clk;

  modn_down_counter_if #(.WIDTH(3)) dut_if ();
  modn_down_counter_if #(.WIDTH(3)) st_if ();
  modn_down_counter_if #(.WIDTH(4)) lo_if ();
  modn_down_counter_if #(.WIDTH(4)) hi_if ();

  modn_down_counter #(.MOD(6), .WIDTH(3), .IMPL(ImplBehav)) u_dut (
    .clk (clk), .rst (rst), .bus (dut_if.slave)
  );
  modn_down_counter #(.MOD(6), .WIDTH(3), .IMPL(ImplStruct)) u_dut_st (
    .clk (clk), .rst (rst), .bus (st_if.slave)
  );
  modn_down_counter #(.MOD(6), .WIDTH(4), .IMPL(ImplBehav)) u_lo (
    .clk (clk), .rst (rst_c), .bus (lo_if.slave)
  );
  modn_down_counter #(.MOD(10), .WIDTH(4), .IMPL(ImplStruct)) u_hi (
    .clk (clk), .rst (rst_c), .bus (hi_if.slave)
  );

  assign st_if.en   = dut_if.en;
  assign st_if.bin  = dut_if.bin;
  assign st_if.load = dut_if.load;
  assign st_if.din  = dut_if.din;
  assign hi_if.bin  = lo_if.bout;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  int unsigned exp_q[8]    = '{5, 4, 3, 2, 1, 0, 5, 4};
  int unsigned exp_wrap[8] = '{1, 0, 0, 0, 0, 0, 1, 0};

  int unsigned mq;
  int unsigned mw;
  int unsigned exp_bout;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    rst_c        = 1'b1;
    dut_if.en    = 1'b1;
    dut_if.bin   = 1'b1;
    dut_if.load  = 1'b0;
    dut_if.din   = '0;
    lo_if.en     = 1'b0;
    lo_if.bin    = 1'b1;
    lo_if.load   = 1'b0;
    lo_if.din    = '0;
    hi_if.en     = 1'b0;
    hi_if.load   = 1'b0;
    hi_if.din    = '0;

    // Reset, then free-run through a full period and a bit.
    tick();
    tick();
    check_eq("rst_q", 32'(dut_if.q), 0);
    check_eq("rst_tc", 32'(dut_if.tc), 1);
    check_eq("rst_wrap", 32'(dut_if.wrap), 0);
    check_eq("rst_bout", 32'(dut_if.bout), 1);
    check_eq("rst_st_q", 32'(st_if.q), 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("seq_q[%0d]", i), 32'(dut_if.q), exp_q[i]);
      check_eq($sformatf("seq_wrap[%0d]", i), 32'(dut_if.wrap), exp_wrap[i]);
      check_eq($sformatf("seq_st_q[%0d]", i), 32'(st_if.q), exp_q[i]);
      check_eq($sformatf("seq_tc[%0d]", i), 32'(dut_if.tc), (exp_q[i] == 0) ? 1 : 0);
    end

    // Enable gating at q = 3.
    tick();
    check_eq("gate_start_q", 32'(dut_if.q), 3);
    dut_if.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("gate_en_q", 32'(dut_if.q), 3);
      check_eq("gate_en_wrap", 32'(dut_if.wrap), 0);
      check_eq("gate_en_bout", 32'(dut_if.bout), 0);
    end
    dut_if.en  = 1'b1;
    dut_if.bin = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("gate_bin_q", 32'(dut_if.q), 3);
      check_eq("gate_bin_wrap", 32'(dut_if.wrap), 0);
      check_eq("gate_bin_bout", 32'(dut_if.bout), 0);
    end
    dut_if.bin = 1'b1;

    // Load and clamp.
    dut_if.load = 1'b1;
    dut_if.din  = 3'd2;
    tick();
    check_eq("load2_q", 32'(dut_if.q), 2);
    dut_if.din = 3'd7;
    tick();
    check_eq("load7_clamp_q", 32'(dut_if.q), 5);
    check_eq("load7_clamp_st_q", 32'(st_if.q), 5);
    dut_if.load = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_eq("at_zero_q", 32'(dut_if.q), 0);
    dut_if.load = 1'b1;
    dut_if.din  = 3'd3;
    #1;
    check_eq("bout_ignores_load", 32'(dut_if.bout), 1);
    tick();
    check_eq("load_at_zero_q", 32'(dut_if.q), 3);
    check_eq("load_at_zero_wrap", 32'(dut_if.wrap), 0);

    // Reset beats load mid-operation.
    dut_if.din = 3'd4;
    tick();
    check_eq("pre_rst_q", 32'(dut_if.q), 4);
    rst        = 1'b1;
    dut_if.din = 3'd1;
    tick();
    check_eq("rst_load_q", 32'(dut_if.q), 0);
    check_eq("rst_load_wrap", 32'(dut_if.wrap), 0);
    rst         = 1'b0;
    dut_if.load = 1'b0;
    tick();
    check_eq("resume_q", 32'(dut_if.q), 5);
    check_eq("resume_wrap", 32'(dut_if.wrap), 1);
    rst = 1'b1;
    tick();
    check_eq("rst_clears_wrap", 32'(dut_if.wrap), 0);
    rst = 1'b0;

    // Cascade: low MOD 6 feeding high MOD 10.
    tick();
    check_eq("casc_rst_lo", 32'(lo_if.q), 0);
    check_eq("casc_rst_hi", 32'(hi_if.q), 0);
    rst_c    = 1'b0;
    lo_if.en = 1'b1;
    hi_if.en = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      tick();
      if (e == 1) begin
        check_eq("casc_e1_hi", 32'(hi_if.q), 9);
        check_eq("casc_e1_lo", 32'(lo_if.q), 5);
        check_eq("casc_e1_hi_wrap", 32'(hi_if.wrap), 1);
      end else if (e == 7) begin
        check_eq("casc_e7_hi", 32'(hi_if.q), 8);
        check_eq("casc_e7_lo", 32'(lo_if.q), 5);
      end else if (e == 13) begin
        check_eq("casc_e13_hi", 32'(hi_if.q), 7);
        check_eq("casc_e13_lo", 32'(lo_if.q), 5);
      end
    end

    // Random stimulus against a reference model, both variants in lockstep.
    mq = 0;
    mw = 0;
    for (int c = 0; c < 2000; c++) begin
      rst         = (c == 0) || ($urandom_range(31) == 0);
      dut_if.load = ($urandom_range(5) == 0);
      dut_if.en   = ($urandom_range(3) != 0);
      dut_if.bin  = ($urandom_range(3) != 0);
      dut_if.din  = 3'($urandom_range(7));
      #1;
      if (c > 0) begin
        exp_bout = (dut_if.en && dut_if.bin && mq == 0) ? 1 : 0;
        check_eq("rnd_bout", 32'(dut_if.bout), exp_bout);
        check_eq("rnd_st_bout", 32'(st_if.bout), exp_bout);
      end
      @(posedge clk);
      if (rst) begin
        mq = 0;
        mw = 0;
      end else if (dut_if.load) begin
        mq = (dut_if.din < 6) ? 32'(dut_if.din) : 5;
        mw = 0;
      end else if (dut_if.en && dut_if.bin) begin
        if (mq == 0) begin
          mq = 5;
          mw = 1;
        end else begin
          mq = mq - 1;
          mw = 0;
        end
      end else begin
        mw = 0;
      end
      #1;
      check_eq("rnd_q", 32'(dut_if.q), mq);
      check_eq("rnd_wrap", 32'(dut_if.wrap), mw);
      check_eq("rnd_tc", 32'(dut_if.tc), (mq == 0) ? 1 : 0);
      check_eq("rnd_range", (dut_if.q < 3'd6) ? 1 : 0, 1);
      check_eq("rnd_st_q", 32'(st_if.q), mq);
      check_eq("rnd_st_wrap", 32'(st_if.wrap), mw);
      check_eq("rnd_st_tc", 32'(st_if.tc), (mq == 0) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
